// File: rtl/number_io_pkg.sv
// Shared types and constants for the keypad number-entry and number-output FSMs.
package number_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SEND,
        DONE
    } statetype;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DASH = 8'h2D;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/number_output_fsm_if.sv
// Character stream handshake between the number emitter and its downstream sink.
interface number_output_fsm_if;

    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_out,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_out,
        input  char_valid,
        output char_ready
    );

endinterface

// File: rtl/double_dabble_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per step.
module double_dabble_seq
    import number_io_pkg::*;
#(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  step,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [WIDTH-1:0] bin;
    logic [BCD_W-1:0] adjusted;

    always_comb begin
        adjusted = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top adjusted bit falls off the end; only an overflowing value reaches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin <= '0;
            bcd <= '0;
        end else if (load) begin
            bin <= value;
            bcd <= '0;
        end else if (step) begin
            bcd <= BCD_W'({adjusted, bin[WIDTH-1]});
            bin <= bin << 1;
        end
    end

endmodule

// File: rtl/number_output_fsm.sv
// Converts an unsigned binary value to decimal and streams it as ASCII, MSD first,
// leading zeros suppressed; values that do not fit are sent as a row of dashes.
module number_output_fsm
    import number_io_pkg::*;
#(
    parameter int unsigned MAX_CHARACTERS = 4,
    parameter int unsigned WIDTH          = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    number_output_fsm_if.master chars
);

    localparam int unsigned BCD_W = 4 * MAX_CHARACTERS;
    localparam int unsigned CMP_W = WIDTH + 4;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = (MAX_CHARACTERS > 1) ? $clog2(MAX_CHARACTERS) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_CHARACTERS - 1);

    // Powers of ten that do not fit CMP_W bits saturate, so the zero-extended
    // value can never reach them.
    function automatic logic [CMP_W-1:0] sat_limit(input int unsigned k);
        longint unsigned p;
        p = pow10(k);
        if (CMP_W < 64 && p >= (64'd1 << CMP_W)) begin
            return '1;
        end
        return CMP_W'(p);
    endfunction

    statetype         state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [IDX_W-1:0] digit_idx_q;
    logic             char_valid_q;

    logic [CMP_W-1:0] value_ext;
    logic             value_too_big;
    logic [IDX_W-1:0] lead_idx;
    logic             dd_load;
    logic             dd_step;
    logic [BCD_W-1:0] bcd;
    logic [3:0]       digit;

    assign value_ext = CMP_W'(value);

    // Leading-digit priority encoder: the highest power of ten the value reaches
    // is the index of its most significant nonzero BCD nibble.
    always_comb begin
        value_too_big = (value_ext >= sat_limit(MAX_CHARACTERS));
        lead_idx      = '0;
        for (int unsigned k = 1; k < MAX_CHARACTERS; k++) begin
            if (value_ext >= sat_limit(k)) begin
                lead_idx = IDX_W'(k);
            end
        end
    end

    assign dd_load = (state_q == IDLE) && start;
    assign dd_step = (state_q == CONVERT);

    double_dabble_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (MAX_CHARACTERS)
    ) u_dabble (
        .clk   (clk),
        .reset (reset),
        .load  (dd_load),
        .value (value),
        .step  (dd_step),
        .bcd   (bcd)
    );

    assign digit = bcd[4*int'(digit_idx_q) +: 4];

    always_comb begin
        chars.char_out = 8'h00;
        if (state_q == SEND) begin
            chars.char_out = overflow ? ASCII_DASH : (ASCII_ZERO + {4'h0, digit});
        end
    end

    assign chars.char_valid = char_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            digit_idx_q  <= '0;
            char_valid_q <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= CONVERT;
                        busy        <= 1'b1;
                        bit_cnt_q   <= CNT_INIT;
                        overflow    <= value_too_big;
                        digit_idx_q <= value_too_big ? IDX_LAST : lead_idx;
                    end
                end
                CONVERT: begin
                    bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(1)) begin
                        state_q      <= SEND;
                        char_valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (chars.char_ready) begin
                        if (digit_idx_q == '0) begin
                            state_q      <= DONE;
                            char_valid_q <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            digit_idx_q <= digit_idx_q - IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_number_output_fsm.sv
// Randomised self-checking bench for number_output_fsm against a decimal-string model.
module tb_number_output_fsm;
    import number_io_pkg::*;

    localparam int unsigned MAXC = 4;
    localparam int unsigned W    = 14;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] value;
    logic         busy;
    logic         done;
    logic         overflow;

    number_output_fsm_if chars_if ();

    number_output_fsm #(
        .MAX_CHARACTERS (MAXC),
        .WIDTH          (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .chars    (chars_if)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    byte unsigned exp_q[$];
    bit           exp_ovf;

    function automatic void model(input int unsigned v);
        string s;
        exp_q.delete();
        exp_ovf = (v >= 10 ** MAXC);
        if (exp_ovf) begin
            for (int i = 0; i < int'(MAXC); i++) exp_q.push_back(8'h2D);
        end else begin
            s = $sformatf("%0d", v);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
    endfunction

    // k counts rising edges since the accepting edge; sampling is on falling edges.
    task automatic run(input int unsigned v, input int unsigned stall_first,
                       input bit rand_ready, input bit poke);
        int          got_n;
        int          first_valid_k;
        int          last_xfer_k;
        bit          done_seen;
        bit          holding;
        byte unsigned held;
        int unsigned stall;
        model(v);
        @(negedge clk);
        value = W'(v);
        start = 1'b1;
        chars_if.char_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        value = W'($urandom);
        first_valid_k = -1;
        last_xfer_k   = -1;
        got_n         = 0;
        done_seen     = 1'b0;
        holding       = 1'b0;
        held          = 8'h00;
        stall         = stall_first;
        for (int k = 0; k < 200 && !done_seen; k++) begin
            if (k > 0) @(negedge clk);
            start = (poke && k == 5);
            if (poke && k == 5) value = W'(99);
            if (k == 1) begin
                check("busy_in_convert", busy, 1);
                check("valid_in_convert", chars_if.char_valid, 0);
            end
            if (chars_if.char_valid) begin
                if (first_valid_k < 0) begin
                    first_valid_k = k;
                    check("first_valid_cycle", k, W);
                end
                if (holding) check("held_char", chars_if.char_out, held);
                if (stall > 0) begin
                    chars_if.char_ready = 1'b0;
                    stall--;
                end else if (rand_ready) begin
                    chars_if.char_ready = 1'($urandom_range(0, 1));
                end else begin
                    chars_if.char_ready = 1'b1;
                end
                if (chars_if.char_ready) begin
                    if (got_n < exp_q.size()) begin
                        check("char", chars_if.char_out, exp_q[got_n]);
                    end else begin
                        check("extra_char", got_n, exp_q.size());
                    end
                    got_n++;
                    last_xfer_k = k;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = chars_if.char_out;
                end
            end else begin
                if (holding) check("held_valid", 0, 1);
                holding = 1'b0;
                chars_if.char_ready = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                check("done_cycle", k, last_xfer_k + 1);
                check("overflow", overflow, exp_ovf);
                check("char_count", got_n, exp_q.size());
                check("busy_at_done", busy, 0);
                if (poke) begin
                    start = 1'b1;
                    value = W'(99);
                end
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chars_if.char_ready = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic reset_mid_send();
        bit seen;
        @(negedge clk);
        value = W'(1234);
        start = 1'b1;
        chars_if.char_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = chars_if.char_valid;
        end
        check("rst_test_valid_seen", seen, 1);
        @(negedge clk);
        check("rst_test_second_char", chars_if.char_out, 8'h32);
        reset = 1'b1;
        chars_if.char_ready = 1'b0;
        #1;
        check("rst_async_valid", chars_if.char_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_char", chars_if.char_out, 0);
        check("rst_async_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_idle", busy, 0);
    endtask

    initial begin
        int unsigned v;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        chars_if.char_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        check("reset_valid", chars_if.char_valid, 0);
        check("reset_char", chars_if.char_out, 0);
        reset = 1'b0;
        @(negedge clk);

        run(42, 0, 1'b0, 1'b0);
        run(0, 0, 1'b0, 1'b0);
        run(9999, 0, 1'b0, 1'b0);
        run(10000, 0, 1'b0, 1'b0);
        run(305, 3, 1'b0, 1'b0);
        reset_mid_send();
        run(7, 0, 1'b0, 1'b0);
        run(4321, 0, 1'b0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(9990, 10010);
                2:       v = $urandom_range(16300, 16383);
                default: v = $urandom_range(0, 16383);
            endcase
            run(v, $urandom_range(0, 2), 1'b1, t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/number_output_fsm.md
# number_output_fsm

Serial binary-to-decimal character emitter: the output counterpart of the keypad number-entry FSM. On `start` it latches an unsigned binary value and converts it to BCD with a sequential double-dabble. It then streams the decimal digits, most significant first with leading zeros suppressed, as ASCII bytes over a valid/ready handshake to the downstream character sink (LCD/UART writer). Values too large for `MAX_CHARACTERS` digits are reported as an overflow pattern.

## Interface
- `MAX_CHARACTERS`, 4, maximum decimal digits emitted (1..8).
- `WIDTH`, 14, bit width of `value`; must satisfy WIDTH ≥ 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request conversion; honoured only in IDLE.
- `value` input WIDTH: unsigned number; sampled on the accepting edge.
- `busy` output 1: high in CONVERT and SEND.
- `done` output 1: one-cycle pulse in DONE.
- `overflow` output 1: valid with `done`; high when value ≥ 10^MAX_CHARACTERS.
- `char_out` output 8: ASCII character.
- `char_valid` output 1: `char_out` is valid.
- `char_ready` input 1: sink accepts; a transfer occurs on an edge where `char_valid & char_ready`.

## Operation
- States: IDLE, CONVERT, SEND, DONE.
- IDLE → CONVERT when `start`=1. `value` is latched into the shift register, the BCD register is cleared, the bit counter is set to WIDTH, and the overflow flag is computed as value ≥ 10^MAX_CHARACTERS (constant sized to WIDTH+4 bits).
- CONVERT: one double-dabble step per cycle. Each BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1. After WIDTH steps → SEND.
- BCD register width: 4·MAX_CHARACTERS bits. Bits beyond that are discarded, which matters only in the overflow case.
- On the CONVERT → SEND edge:
  - If not overflow, the digit index loads the position of the most significant nonzero nibble, or 0 if all nibbles are zero, so that value 0 emits a single '0'.
  - If overflow, the index loads MAX_CHARACTERS-1 and every character sent is '-' (8'h2D).
- SEND: `char_valid`=1; `char_out` = 8'h30 + nibble[index], or '-' on overflow.
  - On a transfer: if index = 0 go to DONE, else decrement index.
  - `char_out` and `char_valid` hold stable while `char_ready`=0.
- DONE: `done`=1 and `busy`=0 for exactly one cycle; `overflow` holds its latched value; then → IDLE.
- `start` outside IDLE, including in DONE, is ignored and not queued.
- `value` changes after acceptance have no effect.
- Reset, at any time including mid-SEND: state goes to IDLE and every output goes to 0 immediately. No partial character handshake completes.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow`=0, `char_valid`=0, `char_out`=8'h00.
- `start` accepted at edge N. CONVERT occupies cycles N+1 … N+WIDTH. `char_valid` first rises in cycle N+WIDTH+1.
- With `char_ready` held high, one character transfers per cycle, back to back with no bubbles.
- `done` is asserted in the cycle after the last transfer edge.
- Minimum start-to-start spacing is WIDTH + D + 2 cycles, where D is the number of characters emitted.
- All outputs are registered or decoded from state and registers. There is no combinational path from `char_ready` or `start` to any output.

## Structure
- Package `number_io_pkg`:
  - `statetype` enum, logic [1:0]: IDLE, CONVERT, SEND, DONE.
  - ASCII constants `ASCII_ZERO`=8'h30 and `ASCII_DASH`=8'h2D.
  - Shared with the number-entry FSM.
- Sub-module `double_dabble_seq`, parameterised by WIDTH and DIGITS.
  - Ports: clk, reset, load, value, step, bcd.
  - Performs the +3 and shift step on each `step`.
- Top level owns: state register, bit counter, digit index, leading-zero priority encoder, overflow compare, handshake.

## Test plan
- MAX_CHARACTERS=4, WIDTH=14, value=42, `char_ready`=1 → '4'(8'h34) then '2'(8'h32) on consecutive cycles; first `char_valid` at N+15; `done` at N+17 with `overflow`=0.
- value=0 → single '0'(8'h30), then `done`. value=9999 → "9999" (four 8'h39), `overflow`=0.
- value=10000 → "----" (four 8'h2D); `done` with `overflow`=1.
- value=305 with `char_ready` low for 3 cycles on the first character → '3' held stable and valid for all 3 cycles, then "305" transferred with no lost or duplicated characters.
- Reset asserted mid-SEND after one character of 1234 → `char_valid`, `busy` and `char_out` go to 0 immediately; after release IDLE, and a new start with 7 emits only '7'.
- `start` pulsed with value=99 during CONVERT and during DONE of a prior conversion → ignored; only the original number is emitted and exactly one `done` pulse occurs.
